// File: rtl/exec_wb_unit.sv
// Multi-cycle execute/write-back stage: IDLE -> READ -> EXEC -> WB over an 8x32 register file.
// Optional iterative shift-add multiplier for op 110 is built only when EXEC_MUL_EN is defined.
module exec_wb_unit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_issue_valid,
  output logic        o_issue_ready,
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_rs1,
  input  logic [2:0]  i_rs2,
  input  logic [2:0]  i_rd,
  output logic [2:0]  o_ra1,
  output logic [2:0]  o_ra2,
  input  logic [31:0] i_rd1,
  input  logic [31:0] i_rd2,
  output logic [2:0]  o_wa,
  output logic [31:0] o_wd,
  output logic        o_we,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [2:0]  r_rd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] w_result;
  logic        w_legal;
  logic        w_exec_done;

`ifdef EXEC_MUL_EN
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic        w_is_mul;
  logic [31:0] w_acc_next;

  assign w_is_mul    = (r_op == 3'b110);
  assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_legal     = 1'b1;
  assign w_exec_done = !w_is_mul || (r_cnt == 5'd31);

  // Multiply accumulator and iteration counter, cleared as EXEC is entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc <= 32'd0;
      r_cnt <= 5'd0;
    end else if (r_state == S_READ) begin
      r_acc <= 32'd0;
      r_cnt <= 5'd0;
    end else if (r_state == S_EXEC && w_is_mul) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 5'd1;
    end
  end
`else
  assign w_legal     = (r_op != 3'b110);
  assign w_exec_done = 1'b1;
`endif

  // Operand registers: loaded from the read ports in READ, shifted while multiplying
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a <= 32'd0;
      r_b <= 32'd0;
    end else if (r_state == S_READ) begin
      r_a <= i_rd1;
      r_b <= i_rd2;
    end
`ifdef EXEC_MUL_EN
    else if (r_state == S_EXEC && w_is_mul) begin
      r_a <= {r_a[30:0], 1'b0};
      r_b <= {1'b0, r_b[31:1]};
    end
`endif
  end

  // ALU result for the latched op
  always_comb begin
    w_result = 32'd0;
    case (r_op)
      3'b000:  w_result = r_a + r_b;
      3'b001:  w_result = r_a - r_b;
      3'b010:  w_result = r_a & r_b;
      3'b011:  w_result = r_a | r_b;
      3'b100:  w_result = r_a ^ r_b;
      3'b101:  w_result = {31'd0, ($signed(r_a) < $signed(r_b))};
`ifdef EXEC_MUL_EN
      3'b110:  w_result = w_acc_next;
`else
      3'b110:  w_result = 32'd0;
`endif
      3'b111:  w_result = r_a << r_b[4:0];
      default: w_result = 32'd0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_issue_valid && o_issue_ready) w_next = S_READ;
        else                                 w_next = S_IDLE;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        if (w_exec_done) w_next = S_WB;
        else             w_next = S_EXEC;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched instruction fields and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_rd          <= 3'd0;
      o_issue_ready <= 1'b1;
      o_busy        <= 1'b0;
      o_we          <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_ra1         <= 3'd0;
      o_ra2         <= 3'd0;
      o_wa          <= 3'd0;
      o_wd          <= 32'd0;
    end else begin
      r_state       <= w_next;
      o_issue_ready <= (w_next == S_IDLE);
      o_busy        <= (w_next != S_IDLE);
      o_we          <= (w_next == S_WB) && w_legal;
      o_done        <= (w_next == S_WB);
      o_err         <= (w_next == S_WB) && !w_legal;
      if (r_state == S_IDLE && i_issue_valid && o_issue_ready) begin
        r_op  <= i_op;
        r_rd  <= i_rd;
        o_ra1 <= i_rs1;
        o_ra2 <= i_rs2;
      end
      if (w_next == S_WB) begin
        o_wa <= r_rd;
        if (w_legal) o_wd <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_unit.sv
// Self-checking bench for exec_wb_unit: register-file model, directed cases, then random instructions
// compared against an arithmetic reference model with cycle-exact handshake checks.
module tb_exec_wb_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [2:0]  i_op, i_rs1, i_rs2, i_rd;
  logic [2:0]  o_ra1, o_ra2, o_wa;
  logic [31:0] i_rd1, i_rd2, o_wd;
  logic        o_we, o_done, o_err, o_busy;

  logic [31:0] regs [8];
  logic [31:0] snap_r [8];
  logic        pl_en;
  logic [2:0]  pl_a;
  logic [31:0] pl_d;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n, we_cnt, mism;
  int acc_cyc [3];
  logic [2:0] op_r;

`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  exec_wb_unit dut (
    .clk(clk), .n_rst(n_rst),
    .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .o_ra1(o_ra1), .o_ra2(o_ra2), .i_rd1(i_rd1), .i_rd2(i_rd2),
    .o_wa(o_wa), .o_wd(o_wd), .o_we(o_we),
    .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
  );

  assign i_rd1 = regs[o_ra1];
  assign i_rd2 = regs[o_ra2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_we) regs[o_wa] <= o_wd;
    if (pl_en) regs[pl_a] <= pl_d;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a * b;
      default: return a << b[4:0];
    endcase
  endfunction

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  function automatic int count_diff();
    int m = 0;
    for (int i = 0; i < 8; i++) if (regs[i] !== snap_r[i]) m++;
    return m;
  endfunction

  // Issue one instruction and check every cycle until it retires
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    logic [31:0] a, b, exp;
    bit legal;
    int lat, w;
    w = 0;
    while (!o_issue_ready && w < 100) begin @(posedge clk); #1; w++; end
    check_val("ready_wait", 32'(w < 100), 32'd1);
    a = regs[rs1]; b = regs[rs2];
    exp   = ref_result(op, a, b);
    legal = (op != 3'd6) || MUL_ON;
    lat   = (op == 3'd6 && MUL_ON) ? 34 : 3;
    snap_r = regs;
    if (legal) snap_r[rd] = exp;
    i_op = op; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_issue_valid = 1'b1;
    @(posedge clk); #1;
    i_issue_valid = 1'b0;
    i_op = 3'($urandom); i_rs1 = 3'($urandom); i_rs2 = 3'($urandom); i_rd = 3'($urandom);
    check_val("read_addr", {26'd0, o_ra1, o_ra2}, {26'd0, rs1, rs2});
    for (int k = 1; k <= lat; k++) begin
      check_val("ctl", {27'd0, o_busy, o_issue_ready, o_done, o_we, o_err},
                {27'd0, 1'b1, 1'b0, (k == lat), (k == lat) && legal, (k == lat) && !legal});
      if (k == lat && legal) begin
        check_val("wa", {29'd0, o_wa}, {29'd0, rd});
        check_val("wd", o_wd, exp);
      end
      if (k < lat) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check_val("idle_ctl", {27'd0, o_busy, o_issue_ready, o_done, o_we, o_err}, 32'b01000);
    if (legal) check_val("wd_hold", o_wd, exp);
    check_val("regfile_diff", 32'(count_diff()), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; i_issue_valid = 1'b0; pl_en = 1'b0;
    i_op = 3'd0; i_rs1 = 3'd0; i_rs2 = 3'd0; i_rd = 3'd0; pl_a = 3'd0; pl_d = 32'd0;
    for (int i = 0; i < 8; i++) preload(3'(i), 32'(i + 1));
    check_val("rst_ctl", {27'd0, o_busy, o_issue_ready, o_done, o_we, o_err}, 32'b01000);
    check_val("rst_addr", {23'd0, o_wa, o_ra1, o_ra2}, 32'd0);
    check_val("rst_wd", o_wd, 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_instr(3'd0, 3'd0, 3'd1, 3'd2);
    check_val("add_const", regs[2], 32'd3);
    run_instr(3'd1, 3'd0, 3'd1, 3'd3);
    check_val("sub_const", regs[3], 32'hFFFF_FFFF);
    preload(3'd4, 32'hFFFF_FFFF); preload(3'd5, 32'd1);
    run_instr(3'd5, 3'd4, 3'd5, 3'd6);
    check_val("slt_const", regs[6], 32'd1);
    preload(3'd4, 32'd3); preload(3'd5, 32'h21);
    run_instr(3'd7, 3'd4, 3'd5, 3'd6);
    check_val("shl_const", regs[6], 32'd6);
    preload(3'd4, 32'h0001_0003); preload(3'd5, 32'd5); preload(3'd7, 32'h1234_5678);
    run_instr(3'd6, 3'd4, 3'd5, 3'd7);
    check_val("mul_const", regs[7], MUL_ON ? 32'h0005_000F : 32'h1234_5678);
    run_instr(3'd2, 3'd4, 3'd5, 3'd1);

    // Back-to-back dependent ADDs with valid held high
    preload(3'd0, 32'd10); preload(3'd1, 32'd20);
    i_issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_op  = 3'd0;
      i_rs1 = (i == 0) ? 3'd0 : ((i == 1) ? 3'd2 : 3'd3);
      i_rs2 = (i == 0) ? 3'd1 : ((i == 1) ? 3'd1 : 3'd2);
      i_rd  = 3'(i + 2);
      n = 0;
      while (!o_issue_ready && n < 20) begin @(posedge clk); #1; n++; end
      check_val("b2b_wait", 32'(n < 20), 32'd1);
      acc_cyc[i] = cyc;
      @(posedge clk); #1;
    end
    i_issue_valid = 1'b0;
    n = 0;
    while (!o_issue_ready && n < 20) begin @(posedge clk); #1; n++; end
    check_val("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check_val("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check_val("b2b_r2", regs[2], 32'd30);
    check_val("b2b_r3", regs[3], 32'd50);
    check_val("b2b_r4", regs[4], 32'd80);

    // Reset pulse in the middle of an instruction
    preload(3'd0, 32'd7); preload(3'd1, 32'd9);
    snap_r = regs;
    op_r = MUL_ON ? 3'd6 : 3'd0;
    i_op = op_r; i_rs1 = 3'd0; i_rs2 = 3'd1; i_rd = 3'd5; i_issue_valid = 1'b1;
    @(posedge clk); #1;
    i_issue_valid = 1'b0;
    repeat (MUL_ON ? 11 : 1) begin @(posedge clk); #1; end
    n_rst = 1'b0; #1;
    check_val("mid_rst_ctl", {27'd0, o_busy, o_issue_ready, o_done, o_we, o_err}, 32'b01000);
    check_val("mid_rst_addr", {23'd0, o_wa, o_ra1, o_ra2}, 32'd0);
    check_val("mid_rst_wd", o_wd, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (o_we) we_cnt++; end
    check_val("mid_rst_no_we", 32'(we_cnt), 32'd0);
    check_val("mid_rst_regfile", 32'(count_diff()), 32'd0);
    run_instr(3'd0, 3'd0, 3'd1, 3'd5);
    check_val("post_rst_add", regs[5], 32'd16);

    // Random instructions against the reference model
    for (int i = 0; i < 8; i++) preload(3'(i), $urandom);
    for (int i = 0; i < 40; i++)
      run_instr(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
